piezo_tone_gen: RTL
===================

# piezo_tone_gen

Parametrised single-clock tone generator that turns a one-hot 12-key keypad code into a square wave for the piezo buzzer. It sits between the keypad scanner's `key_data[11:0]` and the board's piezo pin. It adds over the first-generation tone block:

- a run-time octave register driven by dedicated keys;
- glitch-free retuning;
- clock-enable timing instead of a derived clock;
- optional note sustain after key release.

## Interface

Parameters:

- `TICK_DIV`, 50: `clk` cycles per 1 µs tone tick.
- `CNT_W`, 12: width of the tone half-period counter.
- `SUSTAIN_TICKS`, 200000: ticks a note keeps sounding after release. Used only when sustain is compiled in.
- `SUS_W`, 18: width of the sustain counter. Must satisfy 2^SUS_W > SUSTAIN_TICKS.

Ports:

- `clk`, input, 1: system clock. Single clock domain.
- `rst`, input, 1: reset. Synchronous and active-high, sampled on the rising edge of `clk`.
- `key_data`, input, 12: one-hot key code from the keypad scanner.
- `piezo_out`, output, 1: square wave to the piezo.
- `busy`, output, 1: high while a tone is sounding (state PLAY or SUSTAIN).
- `note_idx`, output, 4: 0 means silent; 1..8 means C, D, E, F, G, A, B, C'.
- `octave`, output, 2: current octave, 0..3.

## Operation

Input register:
- `key_q` registers `key_data` every `clk` cycle.
- `key_p` holds the previous value of `key_q`.

Key decode of `key_q`. Only an exact one-hot value is valid; any other value, including zero, counts as "no key".
- Bits 0..7 are note keys 1..8. Base half-periods in ticks: 956, 851, 758, 716, 638, 568, 506, 478.
- Bit 8 (key 9) is ignored and treated as no key.
- Bit 9 (`*`): octave down on its press edge (`key_q[9] & ~key_p[9]`). Saturates at 0.
- Bit 10 (`0`): octave reset to 1 on its press edge.
- Bit 11 (`#`): octave up on its press edge. Saturates at 3.

Half-period:
- `half = (base << 1) >> octave`, computed in CNT_W bits.
- Octave 1 gives the base value; octave 0 gives 2×base (at most 1912); octave 3 gives base/4.

Tick generator:
- `div_cnt` counts 0..TICK_DIV-1 continuously.
- `tick` is high for one cycle when `div_cnt == TICK_DIV-1`.

Tone counter:
- `cnt` advances only on `tick`.
- On a tick with `cnt >= half-1`: `cnt` goes to 0 and `piezo_out` toggles.
- Using `>=` means a mid-tone octave change to a shorter period toggles on the next tick, never wraps.

FSM states: IDLE, PLAY, SUSTAIN.

IDLE:
- `piezo_out` = 0, `cnt` = 0, `note_idx` = 0.
- A valid note key moves to PLAY: load `note_idx`, clear `cnt`, clear `piezo_out`.

PLAY:
- Same note still held: keep counting.
- A different valid note: retune. Load the new `note_idx` and clear `cnt`. `piezo_out` holds its level, so no runt pulse occurs.
- No note key (release, octave key, or invalid code):
  - With sustain compiled in: go to SUSTAIN and clear `sus_cnt`.
  - Without sustain: go to IDLE.

SUSTAIN:
- Keeps toggling at the held note.
- `sus_cnt` increments on each tick.
- Any valid note key goes to PLAY with the retune rule.
- When `sus_cnt == SUSTAIN_TICKS-1` on a tick, go to IDLE.

Octave handling:
- Octave keys work in every state.
- The octave is kept through note changes. Only reset and key `0` restore it to 1.

Reset values: `piezo_out` = 0, `busy` = 0, `note_idx` = 0, `octave` = 1, state IDLE, `div_cnt` = `cnt` = `sus_cnt` = 0, `key_q` = `key_p` = 0.

Asserting `rst` mid-tone forces all reset values on that edge. There is no partial state.

## Timing

- A `key_data` change at edge n is in `key_q` after edge n+1. The state, `note_idx`, `busy` and `octave` update at edge n+2.
- The first `piezo_out` rise comes `half` ticks after PLAY is entered. After that the output toggles every `half × TICK_DIV` clk cycles, exactly.
- Without sustain, `piezo_out` is 0 from edge n+2 after release.
- `tick` phase is free-running and is not reset on key events. The first toggle may therefore land up to TICK_DIV-1 cycles early relative to the PLAY edge. Benches must measure subsequent periods.
- All outputs are registered.

## Configuration

Macro: `PIEZO_SUSTAIN_EN`.

- Defined: the SUSTAIN state and `sus_cnt` exist. After release the tone continues for SUSTAIN_TICKS ticks, and `busy` stays high until IDLE.
- Undefined: the SUSTAIN state and counter are not built. Release goes directly to IDLE, and SUSTAIN_TICKS and SUS_W are unused.

## Test plan

1. **Reset.** Hold `rst` for 3 cycles with `key_data` = 12'h001. Required: `piezo_out` = 0, `busy` = 0, `note_idx` = 0, `octave` = 1 throughout. After release, `note_idx` = 1 within 2 edges.
2. **Base tone.** TICK_DIV=50, hold 12'h001. Required: after the first toggle, the `piezo_out` half-period is 47800 clk.
   - Switch to 12'h020 (A). Required: `note_idx` = 6, half-period 28400 clk, no pulse shorter than the old level's elapsed time.
3. **Octave up/down.** Press and release `#` (12'h800) once, then hold 12'h020. Required: `octave` = 2, half = 284 ticks.
   - Press `*` four times. Required: `octave` saturates at 0. Hold 12'h001. Required: half = 1912 ticks.
   - Press `0`. Required: `octave` = 1.
4. **Invalid codes.** Drive 12'h003, then 12'h100, from IDLE. Required: state stays IDLE, `piezo_out` = 0, `busy` = 0.
   - Drive 12'h003 while playing. Required: treated as a release.
5. **Release and sustain.** TICK_DIV=2, SUSTAIN_TICKS=10, play 12'h001 then release.
   - With `PIEZO_SUSTAIN_EN`: toggling continues, `busy` = 1 for 10 ticks (20 clk), then IDLE with `piezo_out` = 0. A new key 12'h004 pressed during sustain gives `note_idx` = 3 with no return to IDLE.
   - Without the macro: `busy` = 0 and `piezo_out` = 0 two edges after release.
6. **Reset mid-tone.** Assert `rst` for 1 cycle while in PLAY at octave 3. Required: next edge shows all reset values, `octave` = 1. With the key still held, the tone restarts at octave 1.

Source files
------------

// File: rtl/piezo_tone_gen.sv
// One-hot keypad code to piezo square wave, with run-time octave keys and glitch-free retune.
// Define PIEZO_SUSTAIN_EN to build the post-release SUSTAIN state and its counter.
module piezo_tone_gen #(
  parameter int TICK_DIV      = 50,
  parameter int CNT_W         = 12,
  parameter int SUSTAIN_TICKS = 200000,
  parameter int SUS_W         = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] key_data,
  output logic        piezo_out,
  output logic        busy,
  output logic [3:0]  note_idx,
  output logic [1:0]  octave
);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE,
    PLAY
`ifdef PIEZO_SUSTAIN_EN
    , SUSTAIN
`endif
  } state_t;

  if ((64'd1 << SUS_W) <= 64'(SUSTAIN_TICKS)) begin : g_bad_sus_w
    $error("SUS_W too narrow for SUSTAIN_TICKS");
  end

  state_t           state;
  logic [11:0]      key_q;
  logic [11:9]      key_p;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] cnt, base, half;
  logic             tick, wrap;
  logic             note_vld;
  logic [3:0]       note_key;
  logic             dn_edge, rs_edge, up_edge;
`ifdef PIEZO_SUSTAIN_EN
  logic [SUS_W-1:0] sus_cnt;
`endif

  assign tick    = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign dn_edge = key_q[9]  & ~key_p[9];
  assign rs_edge = key_q[10] & ~key_p[10];
  assign up_edge = key_q[11] & ~key_p[11];

  // Only an exact one-hot code on bits 0..7 is a note; everything else is "no key".
  always_comb begin
    note_vld = 1'b0;
    note_key = 4'd0;
    if (key_q != 12'd0 && (key_q & (key_q - 12'd1)) == 12'd0) begin
      for (int i = 0; i < 8; i++) begin
        if (key_q[i]) begin
          note_vld = 1'b1;
          note_key = 4'(i + 1);
        end
      end
    end
  end

  always_comb begin
    case (note_idx)
      4'd1:    base = CNT_W'(956);
      4'd2:    base = CNT_W'(851);
      4'd3:    base = CNT_W'(758);
      4'd4:    base = CNT_W'(716);
      4'd5:    base = CNT_W'(638);
      4'd6:    base = CNT_W'(568);
      4'd7:    base = CNT_W'(506);
      4'd8:    base = CNT_W'(478);
      default: base = '0;
    endcase
    half = (base << 1) >> octave;
  end

  // >= lets a mid-tone switch to a shorter period toggle on the next tick instead of wrapping.
  assign wrap = tick && (cnt >= half - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_q     <= '0;
      key_p     <= '0;
      div_cnt   <= '0;
      cnt       <= '0;
      piezo_out <= 1'b0;
      busy      <= 1'b0;
      note_idx  <= 4'd0;
      octave    <= 2'd1;
`ifdef PIEZO_SUSTAIN_EN
      sus_cnt   <= '0;
`endif
    end else begin
      key_q   <= key_data;
      key_p   <= key_q[11:9];
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);

      if (rs_edge)
        octave <= 2'd1;
      else if (dn_edge && octave != 2'd0)
        octave <= octave - 2'd1;
      else if (up_edge && octave != 2'd3)
        octave <= octave + 2'd1;

      // Free-running tone step; the state branches below override it on loads and in IDLE.
      if (tick) begin
        if (wrap) begin
          cnt       <= '0;
          piezo_out <= ~piezo_out;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      case (state)
        IDLE: begin
          cnt       <= '0;
          piezo_out <= 1'b0;
          note_idx  <= 4'd0;
          if (note_vld) begin
            state    <= PLAY;
            busy     <= 1'b1;
            note_idx <= note_key;
          end
        end
        PLAY: begin
          if (note_vld) begin
            if (note_key != note_idx) begin
              note_idx  <= note_key;
              cnt       <= '0;
              piezo_out <= piezo_out;
            end
          end else begin
`ifdef PIEZO_SUSTAIN_EN
            state   <= SUSTAIN;
            sus_cnt <= '0;
`else
            state     <= IDLE;
            busy      <= 1'b0;
            note_idx  <= 4'd0;
            cnt       <= '0;
            piezo_out <= 1'b0;
`endif
          end
        end
`ifdef PIEZO_SUSTAIN_EN
        SUSTAIN: begin
          if (note_vld) begin
            state     <= PLAY;
            note_idx  <= note_key;
            cnt       <= '0;
            piezo_out <= piezo_out;
          end else if (tick) begin
            if (sus_cnt == SUS_W'(SUSTAIN_TICKS - 1)) begin
              state     <= IDLE;
              busy      <= 1'b0;
              note_idx  <= 4'd0;
              cnt       <= '0;
              piezo_out <= 1'b0;
            end else begin
              sus_cnt <= sus_cnt + SUS_W'(1);
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule
